// File: rtl/data_mem_responder_pkg.sv
// Shared constants and FSM encoding for the data-memory responder and its storage array.
package data_mem_responder_pkg;

    localparam int   RegDataBus    = 32;
    localparam int   DataMemNumLog = 10;
    localparam int   DataMemNum    = 1 << DataMemNumLog;
    localparam logic WriteEnable   = 1'b1;
    localparam logic ReadEnable    = 1'b1;

    // Wide enough for the largest legal latency (15).
    localparam int   CntW          = 4;

    typedef enum logic [1:0] {
        MemIdle = 2'd0,
        MemWait = 2'd1,
        MemResp = 2'd2
    } memState_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response channel between the MEM stage (master) and the data-memory responder (slave).
interface data_mem_responder_if
    import data_mem_responder_pkg::*;
#(
    parameter int DATA_W = RegDataBus
);

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [DATA_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic              resp_write;
    logic [DATA_W-1:0] resp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_write, resp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_write, resp_rdata
    );

endinterface

// File: rtl/data_mem_responder_ram.sv
// Word storage with synchronous write and a registered read port; only the read register is reset.
module data_ram_array
    import data_mem_responder_pkg::*;
#(
    parameter int DATA_W = RegDataBus,
    parameter int ADDR_W = DataMemNumLog
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(1 << ADDR_W)-1];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we == WriteEnable) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // Read register only changes on a load accept, so it holds steady for the whole response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re == ReadEnable) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding load/store responder with a configurable fixed access latency (1..15 cycles).
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DATA_W  = RegDataBus,
    parameter int ADDR_W  = DataMemNumLog,
    parameter int LATENCY = 2
) (
    input logic                 clk,
    input logic                 rst,
    data_mem_responder_if.slave bus
);

    memState_t         r_state;
    memState_t         w_nextState;
    logic [CntW-1:0]   r_cnt;
    logic              r_respWrite;
    logic              w_accept;
    logic              w_ramWe;
    logic              w_ramRe;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_ramRdata;

    assign w_accept = bus.req_valid && (r_state == MemIdle);
    assign w_addr   = bus.req_addr[ADDR_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= MemIdle;
            r_cnt       <= '0;
            r_respWrite <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (w_accept) begin
                r_cnt       <= CntW'(LATENCY - 1);
                r_respWrite <= bus.req_write;
            end else if ((r_state == MemWait) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // A counter value of 1 in WAIT means the response becomes visible after this edge.
    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            MemIdle: begin
                if (bus.req_valid) begin
                    w_nextState = (LATENCY == 1) ? MemResp : MemWait;
                end
            end
            MemWait: begin
                if (r_cnt <= CntW'(1)) begin
                    w_nextState = MemResp;
                end
            end
            MemResp: begin
                if (bus.resp_ready) begin
                    w_nextState = MemIdle;
                end
            end
            default: w_nextState = MemIdle;
        endcase
    end

    always_comb begin
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        w_ramWe        = ~WriteEnable;
        w_ramRe        = ~ReadEnable;
        unique case (r_state)
            MemIdle: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    if (bus.req_write) begin
                        w_ramWe = WriteEnable;
                    end else begin
                        w_ramRe = ReadEnable;
                    end
                end
            end
            MemResp: bus.resp_valid = 1'b1;
            default: ;
        endcase
    end

    assign bus.resp_write = r_respWrite;
    assign bus.resp_rdata = r_respWrite ? '0 : w_ramRdata;

    data_ram_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_ramWe),
        .i_re    (w_ramRe),
        .i_addr  (w_addr),
        .i_wdata (bus.req_wdata),
        .o_rdata (w_ramRdata)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench: a transaction-level model of the responder checked every cycle,
// plus latency/spacing measurements on LATENCY=1 and LATENCY=15 instances.
module tb_data_mem_responder;

    localparam int Lat = 2;

    logic clk;
    logic rstMain;
    logic rstAux;

    int checks = 0;
    int errors = 0;

    data_mem_responder_if #(.DATA_W(32)) bus2 ();
    data_mem_responder_if #(.DATA_W(32)) bus1 ();
    data_mem_responder_if #(.DATA_W(32)) bus15 ();

    data_mem_responder #(.DATA_W(32), .ADDR_W(10), .LATENCY(Lat)) dut2 (
        .clk (clk), .rst (rstMain), .bus (bus2)
    );
    data_mem_responder #(.DATA_W(32), .ADDR_W(10), .LATENCY(1)) dut1 (
        .clk (clk), .rst (rstAux), .bus (bus1)
    );
    data_mem_responder #(.DATA_W(32), .ADDR_W(10), .LATENCY(15)) dut15 (
        .clk (clk), .rst (rstAux), .bus (bus15)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transaction-level model: one pending response, visible from sample respAt until handshaken.
    logic [31:0] modelMem [int];
    bit          busy = 0;
    int          respAt = 0;
    bit          expWrite = 0;
    logic [31:0] expData = '0;
    bit          expKnown = 0;
    int          k = 0;

    logic        sReqReady;
    logic        sRespValid;
    logic        sRespWrite;
    logic [31:0] sRdata;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h (sample %0d)", name, act, req, k);
        end
    endtask

    task automatic checkOutput();
        bit showing;
        @(negedge clk);
        k++;
        sReqReady  = bus2.req_ready;
        sRespValid = bus2.resp_valid;
        sRespWrite = bus2.resp_write;
        sRdata     = bus2.resp_rdata;
        showing    = busy && (k >= respAt);
        cmp("req_ready", {31'd0, sReqReady}, {31'd0, !busy});
        cmp("resp_valid", {31'd0, sRespValid}, {31'd0, showing});
        if (showing) begin
            cmp("resp_write", {31'd0, sRespWrite}, {31'd0, expWrite});
            if (expKnown) cmp("resp_rdata", sRdata, expData);
        end
    endtask

    // Drives the inputs for the coming edge and advances the model across that edge.
    task automatic applyStimulus(input logic v, input logic w, input logic [31:0] a,
                                 input logic [31:0] d, input logic rr);
        int idx;
        bus2.req_valid  = v;
        bus2.req_write  = w;
        bus2.req_addr   = a;
        bus2.req_wdata  = d;
        bus2.resp_ready = rr;
        idx = int'(a % 1024);
        if (rstMain) begin
            busy = 0;
        end else if (!busy && v) begin
            busy     = 1;
            respAt   = k + Lat;
            expWrite = w;
            if (w) begin
                modelMem[idx] = d;
                expData       = '0;
                expKnown      = 1;
            end else begin
                expKnown = modelMem.exists(idx);
                expData  = expKnown ? modelMem[idx] : '0;
            end
        end else if (busy && (k >= respAt) && rr) begin
            busy = 0;
        end
    endtask

    task automatic runTxn(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input int hold, output logic [31:0] got, output logic gotWrite,
                          output int lat);
        int  kAcc;
        int  held;
        bit  done;
        checkOutput();
        applyStimulus(1'b1, w, a, d, 1'b0);
        kAcc     = k;
        lat      = -1;
        held     = 0;
        done     = 0;
        got      = '0;
        gotWrite = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            checkOutput();
            if (sRespValid && lat < 0) begin
                lat      = k - kAcc;
                got      = sRdata;
                gotWrite = sRespWrite;
            end
            if (sRespValid && held >= hold) begin
                applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                              $urandom, 1'b1);
                done = 1;
            end else begin
                if (sRespValid) held++;
                applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                              $urandom, 1'($urandom_range(0, 1)) & !sRespValid);
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL txn_timeout actual=no_response required=response");
        end
    endtask

    int lastAcc [2] = '{-1, -1};
    int pend    [2] = '{-1, -1};
    int nAcc    [2] = '{0, 0};

    task automatic trackAux(input int idx, input int latency, input logic rdy, input logic vld,
                            input int sample);
        if (vld && pend[idx] >= 0) begin
            cmp($sformatf("accept_to_resp_L%0d", latency), 32'(sample - pend[idx]),
                32'(latency));
            pend[idx] = -1;
        end
        if (rdy) begin
            if (lastAcc[idx] >= 0) begin
                cmp($sformatf("accept_spacing_L%0d", latency), 32'(sample - lastAcc[idx]),
                    32'(latency + 1));
            end
            lastAcc[idx] = sample;
            pend[idx]    = sample;
            nAcc[idx]++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        logic [31:0] got;
        logic        gotW;
        int          lat;
        logic [31:0] a;

        rstMain = 1'b1;
        rstAux  = 1'b1;
        bus2.req_valid = 0; bus2.req_write = 0; bus2.req_addr = '0; bus2.req_wdata = '0;
        bus2.resp_ready = 0;
        bus1.req_valid = 1; bus1.req_write = 1; bus1.req_addr = 32'h3; bus1.req_wdata = 32'h11;
        bus1.resp_ready = 1;
        bus15.req_valid = 1; bus15.req_write = 0; bus15.req_addr = 32'h5; bus15.req_wdata = '0;
        bus15.resp_ready = 1;

        checkOutput();
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
        checkOutput();
        cmp("reset_resp_write", {31'd0, sRespWrite}, 32'd0);
        cmp("reset_resp_rdata", sRdata, 32'd0);
        rstMain = 1'b0;
        rstAux  = 1'b0;
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
        $display("[TB] reset released");

        runTxn(1'b1, 32'h004, 32'hDEADBEEF, 0, got, gotW, lat);
        cmp("store_latency", 32'(lat), 32'd2);
        cmp("store_ack_write", {31'd0, gotW}, 32'd1);
        cmp("store_ack_rdata", got, 32'd0);
        runTxn(1'b0, 32'h004, 32'h0, 0, got, gotW, lat);
        cmp("load_after_store", got, 32'hDEADBEEF);
        cmp("load_resp_write", {31'd0, gotW}, 32'd0);

        runTxn(1'b0, 32'h004, 32'h0, 5, got, gotW, lat);
        cmp("backpressure_rdata", got, 32'hDEADBEEF);

        runTxn(1'b1, 32'h404, 32'h12345678, 0, got, gotW, lat);
        runTxn(1'b0, 32'h004, 32'h0, 1, got, gotW, lat);
        cmp("alias_load", got, 32'h12345678);

        checkOutput();
        applyStimulus(1'b1, 1'b1, 32'h7, 32'hA5A5A5A5, 1'b0);
        checkOutput();
        rstMain = 1'b1;
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
        checkOutput();
        cmp("midreset_resp_valid", {31'd0, sRespValid}, 32'd0);
        cmp("midreset_resp_rdata", sRdata, 32'd0);
        rstMain = 1'b0;
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            checkOutput();
            applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
        end
        runTxn(1'b0, 32'h7, 32'h0, 0, got, gotW, lat);
        cmp("load_after_midreset", got, 32'hA5A5A5A5);

        for (int t = 0; t < 300; t++) begin
            a = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 15) * 61);
            runTxn(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3), got, gotW, lat);
            cmp("random_latency", 32'(lat), 32'(Lat));
            if ($urandom_range(0, 3) == 0) begin
                checkOutput();
                applyStimulus(1'b0, 1'b0, '0, '0, 1'($urandom_range(0, 1)));
            end
        end

        for (int s = 0; s < 90; s++) begin
            @(negedge clk);
            trackAux(0, 1, bus1.req_ready, bus1.resp_valid, s);
            trackAux(1, 15, bus15.req_ready, bus15.resp_valid, s);
        end
        cmp("accepts_seen_L1", {31'd0, nAcc[0] >= 3}, 32'd1);
        cmp("accepts_seen_L15", {31'd0, nAcc[1] >= 3}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Single-port data-memory responder serving the MEM stage's load/store requests over a valid/ready request channel and a valid/ready response channel. Replaces the in-stage memory array with a separate block that models configurable access latency, so the pipeline can be exercised against a memory that stalls. Holds one outstanding transaction at a time.

## Interface
- `DATA_W`, 32, data word width (matches `RegDataBus`)
- `ADDR_W`, 10, word-address width (matches `DataMemNumLog`); depth = 2^ADDR_W words
- `LATENCY`, 2, cycles from request acceptance to `resp_valid`; legal range 1..15
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `req_valid`  in  1  request present
- `req_ready`  out  1  responder can accept a request this cycle
- `req_write`  in  1  1 = store, 0 = load
- `req_addr`  in  DATA_W  byte-agnostic word address; only bits [ADDR_W-1:0] used
- `req_wdata`  in  DATA_W  store data
- `resp_valid`  out  1  response present
- `resp_ready`  in  1  requester consumes response
- `resp_write`  out  1  response is a store acknowledge (1) or load data (0)
- `resp_rdata`  out  DATA_W  load data; 0 for store acknowledges

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: `req_ready`=1. On `req_valid`&`req_ready` (accept): latch `req_write`; for a store, write `req_wdata` to `mem[req_addr[ADDR_W-1:0]]` on the accept edge; for a load, latch `mem[addr]` into the read register on the accept edge (pre-write value irrelevant: one outstanding). Load counter with `LATENCY-1`. Go to RESP if `LATENCY`==1, else WAIT.
- WAIT: `req_ready`=0; decrement counter each cycle; when counter reaches 1, go to RESP next edge.
- RESP: `resp_valid`=1, `resp_write`/`resp_rdata` stable until `resp_ready`=1. On `resp_valid`&`resp_ready`: go to IDLE; `resp_valid` drops next cycle.
- No back-to-back overlap: a new request is accepted no earlier than the cycle after the handshaking response edge.
- Address bits above ADDR_W ignored (wrap-around aliasing is required, not an error).
- `req_*` inputs ignored outside IDLE; `resp_ready` ignored outside RESP.

## Timing
- Reset values: state IDLE, `req_ready`=1 (after reset deasserts), `resp_valid`=0, `resp_write`=0, `resp_rdata`=0, counter 0. Memory contents are not reset.
- `req_ready` is a function of state only (registered); no combinational path from `req_valid` or `resp_ready` to any output.
- Accept at edge N -> `resp_valid` high in the cycle after edge N+LATENCY-1, i.e. exactly LATENCY cycles after the accept cycle.
- Minimum request-to-request spacing with `resp_ready` tied 1: LATENCY+1 cycles.
- Reset mid-transaction: transaction abandoned, no response ever issued; a store committed on its accept edge stays in memory.
- Store to address A followed by load from A returns the stored value.

## Structure
- Constants `DataMemNum`, `DataMemNumLog`, `RegDataBus`, `WriteEnable`, `ReadEnable` and FSM state encodings (`MemIdle`, `MemWait`, `MemResp`, 2 bits) live in the shared macros file.
- One sub-module: `data_ram_array` (synchronous-write, registered-read storage, write enable, address, wdata, rdata); the FSM, counter and response register stay in `data_mem_responder`.

## Test plan
- Reset, LATENCY=2: store 0xDEADBEEF to addr 0x004, `resp_ready`=1 -> `resp_valid`=1, `resp_write`=1, `resp_rdata`=0 two cycles after accept; then load 0x004 -> `resp_rdata`=0xDEADBEEF, `resp_write`=0.
- Backpressure: load with `resp_ready`=0 for 5 cycles -> `resp_valid` and `resp_rdata` held constant, `req_ready`=0 throughout; raise `resp_ready` -> IDLE next cycle, `req_ready`=1.
- Aliasing: store 0x12345678 to addr 0x404 (ADDR_W=10), load addr 0x004 -> 0x12345678.
- LATENCY=1 and LATENCY=15 builds: measured accept-to-`resp_valid` equals parameter; `req_valid` held high continuously -> accepts spaced exactly LATENCY+1 cycles.
- Reset in WAIT after store of 0xA5A5A5A5 to addr 7: `resp_valid` never asserts, outputs at reset values; subsequent load of addr 7 -> 0xA5A5A5A5.
- Request inputs toggled randomly during WAIT/RESP -> no extra accepts, memory unchanged except by accepted stores.
